// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for imm_extend_pipe: instruction input side, immediate output side, flush.
// The master drives instructions and consumes results; the slave is the extender.
interface imm_extend_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) ();
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_ir;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_imm;
  logic [2:0]       out_kind;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output flush, in_valid, in_ir, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_kind, out_tag
  );

  modport slave (
    input  flush, in_valid, in_ir, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_kind, out_tag
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// Two-stage elastic immediate extractor: S1 holds the raw instruction and its decoded kind,
// S2 holds the sign/zero-extended immediate ready for the consumer.
module imm_extend_pipe #(
  parameter int WIDTH  = 32,
  parameter int TAG_W  = 4,
  parameter int PC_ADJ = 4
) (
  input  logic               Clk,
  input  logic               Reset_n,
  imm_extend_pipe_if.slave   bus
);

  typedef enum logic [2:0] {
    KIND_NONE   = 3'd0,
    KIND_SIMM13 = 3'd1,
    KIND_SIMM7  = 3'd2,
    KIND_SHCNT  = 3'd3,
    KIND_DISP22 = 3'd4,
    KIND_DISP30 = 3'd5
  } kind_t;

  logic             s1_valid;
  logic [29:0]      s1_ir;
  logic [TAG_W-1:0] s1_tag;
  kind_t            s1_kind;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_imm;
  kind_t            s2_kind;
  logic [TAG_W-1:0] s2_tag;

  kind_t            in_kind;
  logic [WIDTH-1:0] imm_next;
  logic             s1_advance;
  logic             accept;

  logic [1:0] in_op;
  logic [5:0] in_op3;
  logic       in_i;

  assign in_op  = bus.in_ir[31:30];
  assign in_op3 = bus.in_ir[24:19];
  assign in_i   = bus.in_ir[13];

  // Decode priority: call, branch, register operand, shift count, simm7, simm13.
  always_comb begin
    in_kind = KIND_SIMM13;
    if (in_op == 2'b01)
      in_kind = KIND_DISP30;
    else if (in_op == 2'b00)
      in_kind = KIND_DISP22;
    else if (!in_i)
      in_kind = KIND_NONE;
    else if (in_op == 2'b10 &&
             (in_op3 == 6'b100101 || in_op3 == 6'b100110 || in_op3 == 6'b100111))
      in_kind = KIND_SHCNT;
    else if (in_op == 2'b10 && in_op3 == 6'b111010)
      in_kind = KIND_SIMM7;
  end

  always_comb begin
    imm_next = '0;
    unique case (s1_kind)
      KIND_DISP30: imm_next = WIDTH'($signed({s1_ir[29:0], 2'b00}));
      KIND_DISP22: imm_next = WIDTH'($signed({s1_ir[21:0], 2'b00})) - WIDTH'(PC_ADJ);
      KIND_SHCNT:  imm_next = WIDTH'(s1_ir[4:0]);
      KIND_SIMM7:  imm_next = WIDTH'($signed(s1_ir[6:0]));
      KIND_SIMM13: imm_next = WIDTH'($signed(s1_ir[12:0]));
      default:     imm_next = '0;
    endcase
  end

  // in_ready depends combinationally only on out_ready; everything else is registered.
  assign s1_advance   = !s2_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s1_advance;
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid <= 1'b0;
      s1_ir    <= '0;
      s1_tag   <= '0;
      s1_kind  <= KIND_NONE;
    end else begin
      if (bus.flush)
        s1_valid <= 1'b0;
      else if (bus.in_ready)
        s1_valid <= bus.in_valid;
      if (accept) begin
        s1_ir   <= bus.in_ir[29:0];
        s1_tag  <= bus.in_tag;
        s1_kind <= in_kind;
      end
    end
  end

  // Output data only moves when S2 is empty or being consumed, so it holds under backpressure.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s2_valid <= 1'b0;
      s2_imm   <= '0;
      s2_kind  <= KIND_NONE;
      s2_tag   <= '0;
    end else begin
      if (bus.flush)
        s2_valid <= 1'b0;
      else if (s1_advance)
        s2_valid <= s1_valid;
      if (s1_advance && s1_valid) begin
        s2_imm  <= imm_next;
        s2_kind <= s1_kind;
        s2_tag  <= s1_tag;
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_imm   = s2_imm;
  assign bus.out_kind  = s2_kind;
  assign bus.out_tag   = s2_tag;

endmodule
